keyframe_buffer: RTL and testbench

KEYFRAME_BUFFER -- requirements
Module: keyframe_buffer

---
 rtl/lamp_pkg.sv | 22 ++
 rtl/keyframe_buffer_if.sv | 37 +++
 rtl/lamp_dpram.sv | 26 ++
 rtl/keyframe_buffer.sv | 131 +++++++++++++
 tb/tb_keyframe_buffer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/lamp_pkg.sv
// Shared constants and FSM encoding for the keyframe buffer.
package lamp_pkg;

    localparam int c_bpc          = 12;  // bits per channel
    localparam int c_time_w       = 10;  // keyframe duration width
    localparam int c_type_w       = 6;   // keyframe type width
    localparam int c_ch_per_board = 32;  // channels on one LED board

    // Commit state machine: fill shadow bank, wait for frame boundary, swap.
    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_PENDING = 2'd1,
        S_SWAP    = 2'd2
    } kf_state_e;

    // Number of words per bank once padded to a power of two, so the bank
    // select can sit directly on the RAM address MSB.
    function automatic int bank_words(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/keyframe_buffer_if.sv
// Bus between the SPI decoder / interpolator side and the keyframe buffer.
interface keyframe_buffer_if #(
    parameter int c_addr_w = 10,
    parameter int c_bpc    = lamp_pkg::c_bpc,
    parameter int c_time_w = lamp_pkg::c_time_w,
    parameter int c_type_w = lamp_pkg::c_type_w
);

    // Upstream write side
    logic                i_wen;
    logic [c_addr_w-1:0] i_addr;
    logic [c_bpc-1:0]    i_data;
    logic [c_time_w-1:0] i_time;
    logic [c_type_w-1:0] i_type;
    logic                i_ready;
    logic                i_frame_tick;

    // Downstream read side
    logic [c_addr_w-1:0] i_raddr;
    logic [c_bpc-1:0]    o_rdata;
    logic [c_time_w-1:0] o_time;
    logic [c_type_w-1:0] o_type;
    logic                o_new_kf;
    logic                o_loaded;
    logic                o_drop;

    modport master (
        output i_wen, i_addr, i_data, i_time, i_type, i_ready, i_frame_tick, i_raddr,
        input  o_rdata, o_time, o_type, o_new_kf, o_loaded, o_drop
    );

    modport slave (
        input  i_wen, i_addr, i_data, i_time, i_type, i_ready, i_frame_tick, i_raddr,
        output o_rdata, o_time, o_type, o_new_kf, o_loaded, o_drop
    );

endinterface

// File: rtl/lamp_dpram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// Read-during-write to the same address returns the old contents.
module lamp_dpram #(
    parameter int c_words = 64,
    parameter int c_aw    = 6,
    parameter int c_dw    = 12
) (
    input  logic            i_clk,
    input  logic            i_wen,
    input  logic [c_aw-1:0] i_waddr,
    input  logic [c_dw-1:0] i_wdata,
    input  logic [c_aw-1:0] i_raddr,
    output logic [c_dw-1:0] o_rdata
);

    logic [c_dw-1:0] mem [c_words];

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            mem[i_waddr] <= i_wdata;
        end
        o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/keyframe_buffer.sv
// Double-buffered keyframe store. Writes fill the shadow bank; a completed
// keyframe is committed and the banks swap on the next output frame boundary.
// Build option: define LAMP_KF_TICK_SYNC_EN to hold the swap until
// i_frame_tick; otherwise a commit swaps on the cycle after it is requested.
module keyframe_buffer #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = lamp_pkg::c_bpc,
    parameter int c_channels  = c_ledboards * lamp_pkg::c_ch_per_board,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_time_w    = lamp_pkg::c_time_w,
    parameter int c_type_w    = lamp_pkg::c_type_w
) (
    input  logic              i_clk,
    input  logic              i_rst,
    keyframe_buffer_if.slave  bus
);

    import lamp_pkg::*;

    localparam int             c_ram_aw    = c_addr_w + 1;
    localparam int             c_ram_words = 2 * bank_words(c_addr_w);
    localparam logic [c_addr_w:0] c_chan_lim = (c_addr_w + 1)'(c_channels);

    kf_state_e           state;
    logic                bank;       // currently active (read) bank
    logic [c_time_w-1:0] pend_time;
    logic [c_type_w-1:0] pend_type;
    logic [c_time_w-1:0] cur_time;
    logic [c_type_w-1:0] cur_type;
    logic                new_kf;
    logic                loaded;
    logic                drop;

    logic                accept;
    logic                in_range;
    logic                advance;
    logic                ram_wen;
    logic [c_ram_aw-1:0] ram_waddr;
    logic [c_ram_aw-1:0] ram_raddr;
    logic [c_bpc-1:0]    ram_rdata;

    // Write acceptance, RAM addressing and the pending->swap condition.
    always_comb begin
        accept    = (state != S_PENDING);
        in_range  = ({1'b0, bus.i_addr} < c_chan_lim);
        ram_wen   = accept && bus.i_wen && in_range;
        // bank already reflects the swap during S_SWAP, so reads issued in
        // that cycle see the new keyframe and writes go to the old bank.
        ram_waddr = {~bank, bus.i_addr};
        ram_raddr = {bank, bus.i_raddr};
`ifdef LAMP_KF_TICK_SYNC_EN
        advance   = bus.i_frame_tick;
`else
        advance   = 1'b1;
`endif
    end

`ifndef LAMP_KF_TICK_SYNC_EN
    logic unused_tick;
    assign unused_tick = bus.i_frame_tick;
`endif

    lamp_dpram #(
        .c_words (c_ram_words),
        .c_aw    (c_ram_aw),
        .c_dw    (c_bpc)
    ) u_ram (
        .i_clk   (i_clk),
        .i_wen   (ram_wen),
        .i_waddr (ram_waddr),
        .i_wdata (bus.i_data),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    // Commit FSM with registered outputs; swap effects are applied on entry to
    // S_SWAP so they are visible throughout that cycle. Because S_PENDING is
    // only reached on the edge after i_ready, a tick coincident with i_ready
    // can never trigger the swap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_FILL;
            bank      <= 1'b0;
            pend_time <= '0;
            pend_type <= '0;
            cur_time  <= '0;
            cur_type  <= '0;
            new_kf    <= 1'b0;
            loaded    <= 1'b0;
            drop      <= 1'b0;
        end else begin
            new_kf <= 1'b0;
            case (state)
                S_FILL, S_SWAP: begin
                    if (bus.i_ready) begin
                        pend_time <= bus.i_time;
                        pend_type <= bus.i_type;
                        state     <= S_PENDING;
                    end else begin
                        state     <= S_FILL;
                    end
                end
                S_PENDING: begin
                    if (bus.i_wen || bus.i_ready) begin
                        drop <= 1'b1;
                    end
                    if (advance) begin
                        bank     <= ~bank;
                        cur_time <= pend_time;
                        cur_type <= pend_type;
                        new_kf   <= 1'b1;
                        loaded   <= 1'b1;
                        state    <= S_SWAP;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // Output mapping; read data is masked until a keyframe has been loaded.
    always_comb begin
        bus.o_rdata  = loaded ? ram_rdata : '0;
        bus.o_time   = cur_time;
        bus.o_type   = cur_type;
        bus.o_new_kf = new_kf;
        bus.o_loaded = loaded;
        bus.o_drop   = drop;
    end

endmodule

// File: tb/tb_keyframe_buffer.sv
// Randomized bench for keyframe_buffer (one LED board, 32 channels) against a
// bank/commit model. Honours LAMP_KF_TICK_SYNC_EN the same way the RTL does.
module tb_keyframe_buffer;

    localparam int c_ch  = 32;
    localparam int c_aw  = 5;
    localparam int c_bpc = 12;
    localparam int c_tw  = 10;
    localparam int c_yw  = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    keyframe_buffer_if #(
        .c_addr_w (c_aw),
        .c_bpc    (c_bpc),
        .c_time_w (c_tw),
        .c_type_w (c_yw)
    ) bus ();

    keyframe_buffer #(
        .c_ledboards (1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: two banks with per-word "written" flags, an active index and a
    // pending-commit flag.
    logic [c_bpc-1:0] m_mem   [2][c_ch];
    bit               m_known [2][c_ch];
    int               m_act;
    bit               m_pending;
    bit               m_loaded;
    bit               m_drop;
    logic [c_tw-1:0]  m_time, p_time;
    logic [c_yw-1:0]  m_type, p_type;
    bit               e_new_kf;
    bit               e_rd_valid;
    logic [c_bpc-1:0] e_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act     = 0;
        m_pending = 1'b0;
        m_loaded  = 1'b0;
        m_drop    = 1'b0;
        m_time    = '0;
        m_type    = '0;
        p_time    = '0;
        p_type    = '0;
        e_new_kf  = 1'b0;
        e_rd_valid = 1'b1;
        e_rd      = '0;
    endtask

    // Advance the model by one clock using the inputs held during that cycle.
    task automatic model_step();
        bit               adv;
        logic [c_bpc-1:0] rv;
        bit               rk;
        int               shadow;
        rv     = m_mem[m_act][bus.i_raddr];
        rk     = m_known[m_act][bus.i_raddr];
        shadow = 1 - m_act;
`ifdef LAMP_KF_TICK_SYNC_EN
        adv = bus.i_frame_tick;
`else
        adv = 1'b1;
`endif
        e_new_kf = 1'b0;
        if (m_pending) begin
            if (bus.i_wen || bus.i_ready) m_drop = 1'b1;
            if (adv) begin
                m_act     = shadow;
                m_time    = p_time;
                m_type    = p_type;
                m_loaded  = 1'b1;
                e_new_kf  = 1'b1;
                m_pending = 1'b0;
            end
        end else begin
            if (bus.i_wen) begin
                m_mem[shadow][bus.i_addr]   = bus.i_data;
                m_known[shadow][bus.i_addr] = 1'b1;
            end
            if (bus.i_ready) begin
                p_time    = bus.i_time;
                p_type    = bus.i_type;
                m_pending = 1'b1;
            end
        end
        e_rd_valid = !m_loaded || rk;
        e_rd       = m_loaded ? rv : '0;
    endtask

    task automatic check_outputs();
        if (e_rd_valid) check_eq("rdata", 32'(bus.o_rdata), 32'(e_rd));
        check_eq("time",   32'(bus.o_time),   32'(m_time));
        check_eq("type",   32'(bus.o_type),   32'(m_type));
        check_eq("new_kf", 32'(bus.o_new_kf), 32'(e_new_kf));
        check_eq("loaded", 32'(bus.o_loaded), 32'(m_loaded));
        check_eq("drop",   32'(bus.o_drop),   32'(m_drop));
    endtask

    task automatic clear_strobes();
        bus.i_wen        = 1'b0;
        bus.i_ready      = 1'b0;
        bus.i_frame_tick = 1'b0;
    endtask

    task automatic drive_random();
        bus.i_wen        = ($urandom_range(0, 1) == 1);
        bus.i_addr       = c_aw'($urandom_range(0, c_ch - 1));
        bus.i_data       = c_bpc'($urandom);
        bus.i_time       = c_tw'($urandom);
        bus.i_type       = c_yw'($urandom);
        bus.i_ready      = ($urandom_range(0, 5) == 0);
        bus.i_frame_tick = ($urandom_range(0, 3) == 0);
        bus.i_raddr      = c_aw'($urandom_range(0, c_ch - 1));
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_addr  = '0;
        bus.i_data  = '0;
        bus.i_time  = '0;
        bus.i_type  = '0;
        bus.i_raddr = '0;
        clear_strobes();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < c_ch; a++) begin
                m_mem[b][a]   = '0;
                m_known[b][a] = 1'b0;
            end
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();

        rst = 1'b0;
        drive_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                model_step();
            end
            check_outputs();
            rst = 1'b0;
            if (cyc % 173 == 172) begin
                rst = 1'b1;
                clear_strobes();
            end else begin
                drive_random();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
